// File: rtl/path_oram_ctrl_if.sv
// Request/response bus between a core and the Path ORAM controller.
// The master side issues single-block read/write requests; the slave side
// returns the previous block value and whether the block had been written.
interface path_oram_ctrl_if #(
    parameter int BLOCK_W = 64,
    parameter int L       = 6
);
    logic               req_valid;
    logic               req_ready;
    logic               req_write;
    logic [L-1:0]       req_addr;
    logic [BLOCK_W-1:0] req_wdata;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [BLOCK_W-1:0] rsp_rdata;
    logic               rsp_hit;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_hit
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_hit
    );
endinterface

// File: rtl/path_oram_ctrl.sv
// Path ORAM controller: every access reads one full root-to-leaf path into a
// fully associative stash, serves the request from the stash, remaps the
// block to a fresh LFSR leaf and writes the same path back greedily from the
// leaf upwards. Optional feature: define ORAM_STASH_PEAK_EN to get the
// stash_peak output (maximum stash occupancy since reset).
module path_oram_ctrl #(
    parameter int          BLOCK_W = 64,
    parameter int          L       = 6,
    parameter int          Z       = 4,
    parameter int          STASH   = 16,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst,
    path_oram_ctrl_if.slave              bus,
    output logic [$clog2(STASH+1)-1:0]   stash_cnt,
    output logic                         stash_ovf,
    output logic                         busy
`ifdef ORAM_STASH_PEAK_EN
    ,
    output logic [$clog2(STASH+1)-1:0]   stash_peak
`endif
);
    localparam int NLEAF = 1 << L;
    localparam int NBKT  = (1 << (L + 1)) - 1;
    localparam int NSLOT = NBKT * Z;
    localparam int CW    = $clog2(STASH + 1);
    localparam int SW    = $clog2(STASH);
    localparam int SLW   = $clog2(NSLOT);
    localparam int LVW   = $clog2(L + 1);
    localparam int ZW    = (Z > 1) ? $clog2(Z) : 1;
    localparam int PW    = L + 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, READ, UPDATE, EVICT, RESP} state_t;

    state_t             state;
    logic [15:0]        lfsr;
    logic [15:0]        lfsr_next;
    logic               op_write;
    logic [L-1:0]       op_addr;
    logic [BLOCK_W-1:0] op_wdata;
    logic [L-1:0]       new_leaf;
    logic [L-1:0]       acc_leaf;
    logic               hit;
    logic [BLOCK_W-1:0] rd_data;
    logic [LVW-1:0]     lvl;
    logic [ZW-1:0]      slot;

    logic [NLEAF-1:0]   pm_valid;
    logic [L-1:0]       pm_leaf [NLEAF];
    logic [STASH-1:0]   st_valid;
    logic [L-1:0]       st_addr [STASH];
    logic [L-1:0]       st_leaf [STASH];
    logic [BLOCK_W-1:0] st_data [STASH];
    logic [NSLOT-1:0]   bk_valid;
    logic [L-1:0]       bk_addr [NSLOT];
    logic [L-1:0]       bk_leaf [NSLOT];
    logic [BLOCK_W-1:0] bk_data [NSLOT];

    int                 shamt;
    logic [PW-1:0]      lvl_bit;
    logic [PW-1:0]      path_pref;
    logic [PW-1:0]      path_bkt;
    logic [SLW-1:0]     slot_base;
    logic [SLW-1:0]     ev_slot;
    logic               find_hit;
    logic [SW-1:0]      find_idx;
    logic               free_any;
    logic [SW-1:0]      free_idx;
    logic               ev_any;
    logic [SW-1:0]      ev_idx;
    logic [STASH-1:0]   taken;
    logic [Z-1:0]       mv_en;
    logic [SW-1:0]      mv_idx [Z];
    logic [CW-1:0]      mv_cnt;
    logic               mv_drop;

    assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    // Bucket on the access path at the current level, and its slot addresses
    always_comb begin
        shamt     = L - int'(lvl);
        lvl_bit   = PW'(1) << lvl;
        path_pref = {1'b0, acc_leaf} >> shamt;
        path_bkt  = (lvl_bit | path_pref) - PW'(1);
        slot_base = SLW'(path_bkt) * SLW'(Z);
        ev_slot   = slot_base + SLW'(slot);
    end

    // Lowest-index stash searches: address match, free entry, eviction candidate
    always_comb begin
        find_hit = 1'b0;
        find_idx = '0;
        free_any = 1'b0;
        free_idx = '0;
        ev_any   = 1'b0;
        ev_idx   = '0;
        for (int i = STASH - 1; i >= 0; i--) begin
            if (st_valid[i] && st_addr[i] == op_addr) begin
                find_hit = 1'b1;
                find_idx = SW'(i);
            end
            if (!st_valid[i]) begin
                free_any = 1'b1;
                free_idx = SW'(i);
            end
            if (st_valid[i] && ((st_leaf[i] >> shamt) == (acc_leaf >> shamt))) begin
                ev_any = 1'b1;
                ev_idx = SW'(i);
            end
        end
    end

    // Allocate distinct free stash entries for every valid slot of the bucket being read
    always_comb begin
        taken   = st_valid;
        mv_cnt  = '0;
        mv_drop = 1'b0;
        for (int s = 0; s < Z; s++) begin
            mv_en[s]  = 1'b0;
            mv_idx[s] = '0;
            if (bk_valid[slot_base + SLW'(s)]) begin
                for (int i = STASH - 1; i >= 0; i--) begin
                    if (!taken[i]) begin
                        mv_en[s]  = 1'b1;
                        mv_idx[s] = SW'(i);
                    end
                end
                if (mv_en[s]) begin
                    taken[mv_idx[s]] = 1'b1;
                    mv_cnt           = mv_cnt + CW'(1);
                end else begin
                    mv_drop = 1'b1;
                end
            end
        end
    end

    // Access sequencer: owns all valid bits, counters, LFSR and the response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            lfsr          <= SEED;
            op_write      <= 1'b0;
            op_addr       <= '0;
            op_wdata      <= '0;
            new_leaf      <= '0;
            acc_leaf      <= '0;
            hit           <= 1'b0;
            rd_data       <= '0;
            lvl           <= '0;
            slot          <= '0;
            pm_valid      <= '0;
            st_valid      <= '0;
            bk_valid      <= '0;
            stash_cnt     <= '0;
            stash_ovf     <= 1'b0;
            busy          <= 1'b0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_hit   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_write      <= bus.req_write;
                        op_addr       <= bus.req_addr;
                        op_wdata      <= bus.req_wdata;
                        lfsr          <= lfsr_next;
                        new_leaf      <= lfsr_next[L-1:0];
                        bus.req_ready <= 1'b0;
                        busy          <= 1'b1;
                        state         <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (pm_valid[op_addr]) begin
                        acc_leaf <= pm_leaf[op_addr];
                        hit      <= 1'b1;
                    end else begin
                        acc_leaf <= new_leaf;
                        hit      <= 1'b0;
                    end
                    if (op_write || pm_valid[op_addr]) begin
                        pm_valid[op_addr] <= 1'b1;
                    end
                    lvl   <= '0;
                    state <= READ;
                end
                READ: begin
                    for (int s = 0; s < Z; s++) begin
                        bk_valid[slot_base + SLW'(s)] <= 1'b0;
                        if (mv_en[s]) begin
                            st_valid[mv_idx[s]] <= 1'b1;
                        end
                    end
                    stash_cnt <= stash_cnt + mv_cnt;
                    if (mv_drop) begin
                        stash_ovf <= 1'b1;
                    end
                    if (lvl == LVW'(L)) begin
                        state <= UPDATE;
                    end else begin
                        lvl <= lvl + LVW'(1);
                    end
                end
                UPDATE: begin
                    if (find_hit) begin
                        rd_data <= st_data[find_idx];
                    end else begin
                        rd_data <= '0;
                        if (op_write) begin
                            if (free_any) begin
                                st_valid[free_idx] <= 1'b1;
                                stash_cnt          <= stash_cnt + CW'(1);
                            end else begin
                                stash_ovf <= 1'b1;
                            end
                        end
                    end
                    lvl   <= LVW'(L);
                    slot  <= '0;
                    state <= EVICT;
                end
                EVICT: begin
                    if (ev_any) begin
                        bk_valid[ev_slot] <= 1'b1;
                        st_valid[ev_idx]  <= 1'b0;
                        stash_cnt         <= stash_cnt - CW'(1);
                    end
                    if (slot == ZW'(Z - 1)) begin
                        slot <= '0;
                        if (lvl == '0) begin
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_rdata <= rd_data;
                            bus.rsp_hit   <= hit;
                            state         <= RESP;
                        end else begin
                            lvl <= lvl - LVW'(1);
                        end
                    end else begin
                        slot <= slot + ZW'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Payload storage (leaf, address, data fields) is never reset; valid bits gate it
    always_ff @(posedge clk) begin
        if (state == LOOKUP && (op_write || pm_valid[op_addr])) begin
            pm_leaf[op_addr] <= new_leaf;
        end
        if (state == READ) begin
            for (int s = 0; s < Z; s++) begin
                if (mv_en[s]) begin
                    st_addr[mv_idx[s]] <= bk_addr[slot_base + SLW'(s)];
                    st_leaf[mv_idx[s]] <= bk_leaf[slot_base + SLW'(s)];
                    st_data[mv_idx[s]] <= bk_data[slot_base + SLW'(s)];
                end
            end
        end
        if (state == UPDATE) begin
            if (find_hit) begin
                st_leaf[find_idx] <= new_leaf;
                if (op_write) begin
                    st_data[find_idx] <= op_wdata;
                end
            end else if (op_write && free_any) begin
                st_addr[free_idx] <= op_addr;
                st_leaf[free_idx] <= new_leaf;
                st_data[free_idx] <= op_wdata;
            end
        end
        if (state == EVICT && ev_any) begin
            bk_addr[ev_slot] <= st_addr[ev_idx];
            bk_leaf[ev_slot] <= st_leaf[ev_idx];
            bk_data[ev_slot] <= st_data[ev_idx];
        end
    end

`ifdef ORAM_STASH_PEAK_EN
    // High-water mark of stash occupancy since reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stash_peak <= '0;
        end else if (stash_cnt > stash_peak) begin
            stash_peak <= stash_cnt;
        end
    end
`endif
endmodule

// File: tb/tb_path_oram_ctrl.sv
// Self-checking bench for path_oram_ctrl (L=3, Z=2): directed vector table,
// response-hold and reset-abort sequences, then random traffic against a
// flat memory model of the ORAM's externally visible behaviour.
module tb_path_oram_ctrl;
    localparam int BW  = 64;
    localparam int LL  = 3;
    localparam int ZZ  = 2;
    localparam int ST  = 16;
    localparam int CW  = $clog2(ST + 1);
    localparam int LAT = 1 + (LL + 1) + 1 + (LL + 1) * ZZ;

    typedef struct {
        logic          wr;
        logic [LL-1:0] addr;
        logic [BW-1:0] wdata;
        logic [BW-1:0] exp_rdata;
        logic          exp_hit;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [CW-1:0] stash_cnt;
    logic stash_ovf;
    logic busy;
`ifdef ORAM_STASH_PEAK_EN
    logic [CW-1:0] stash_peak;
`endif

    path_oram_ctrl_if #(.BLOCK_W(BW), .L(LL)) bus ();

    path_oram_ctrl #(
        .BLOCK_W(BW), .L(LL), .Z(ZZ), .STASH(ST), .SEED(16'hACE1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .stash_cnt (stash_cnt),
        .stash_ovf (stash_ovf),
        .busy      (busy)
`ifdef ORAM_STASH_PEAK_EN
        ,
        .stash_peak(stash_peak)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [BW-1:0] ref_mem [1 << LL];
    logic          ref_written [1 << LL];
    int            ref_count;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < (1 << LL); i++) begin
            ref_mem[i]     = '0;
            ref_written[i] = 1'b0;
        end
        ref_count = 0;
    endfunction

    function automatic void modelAccess(input logic wr, input logic [LL-1:0] a, input logic [BW-1:0] wd,
                                        output logic [BW-1:0] exp_rd, output logic exp_hit);
        exp_hit = ref_written[a];
        exp_rd  = ref_written[a] ? ref_mem[a] : '0;
        if (wr) begin
            if (!ref_written[a]) ref_count++;
            ref_mem[a]     = wd;
            ref_written[a] = 1'b1;
        end
    endfunction

    // One full request/response handshake, checked against the given expectation
    task automatic applyStimulus(input logic wr, input logic [LL-1:0] a, input logic [BW-1:0] wd,
                                 input logic [BW-1:0] exp_rd, input logic exp_hit, input int hold);
        int lat;
        @(negedge clk);
        checkOutput("req_ready_idle", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_wdata = {$urandom, $urandom};
        checkOutput("busy_after_accept", 64'(busy), 64'd1);
        lat = 0;
        while (!bus.rsp_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("rsp_arrived", 64'(bus.rsp_valid), 64'd1);
        if (!bus.rsp_valid) return;
        checkOutput("latency", 64'(lat), 64'(LAT));
        checkOutput("rsp_rdata", bus.rsp_rdata, exp_rd);
        checkOutput("rsp_hit", 64'(bus.rsp_hit), 64'(exp_hit));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            checkOutput("hold_rsp_rdata", bus.rsp_rdata, exp_rd);
            checkOutput("hold_rsp_hit", 64'(bus.rsp_hit), 64'(exp_hit));
            checkOutput("hold_req_ready", 64'(bus.req_ready), 64'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        checkOutput("rsp_valid_drop", 64'(bus.rsp_valid), 64'd0);
        checkOutput("req_ready_back", 64'(bus.req_ready), 64'd1);
        checkOutput("stash_ovf", 64'(stash_ovf), 64'd0);
        checkOutput("stash_bound", 64'(int'(stash_cnt) <= ref_count), 64'd1);
    endtask

    // Model-driven access: expectation comes from the flat memory model
    task automatic modelOp(input logic wr, input logic [LL-1:0] a, input logic [BW-1:0] wd, input int hold);
        logic [BW-1:0] e_rd;
        logic          e_hit;
        modelAccess(wr, a, wd, e_rd, e_hit);
        applyStimulus(wr, a, wd, e_rd, e_hit, hold);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [BW-1:0] d_rd;
        logic          d_hit;
        int            seen_rsp;

        // Directed table: values derived by hand from the access rules
        vecs.push_back('{1'b0, 3'd5, 64'h0, 64'h0, 1'b0});
        vecs.push_back('{1'b1, 3'd2, 64'hDEADBEEF_01234567, 64'h0, 1'b0});
        vecs.push_back('{1'b0, 3'd2, 64'h0, 64'hDEADBEEF_01234567, 1'b1});
        vecs.push_back('{1'b0, 3'd2, 64'h0, 64'hDEADBEEF_01234567, 1'b1});
        vecs.push_back('{1'b0, 3'd2, 64'h0, 64'hDEADBEEF_01234567, 1'b1});
        vecs.push_back('{1'b1, 3'd7, 64'h11, 64'h0, 1'b0});
        vecs.push_back('{1'b1, 3'd7, 64'h22, 64'h11, 1'b1});
        vecs.push_back('{1'b0, 3'd7, 64'h0, 64'h22, 1'b1});
        for (int a = 0; a < 8; a++) begin
            vecs.push_back('{1'b1, 3'(a), 64'(a * 32'h0101),
                             (a == 2) ? 64'hDEADBEEF_01234567 : ((a == 7) ? 64'h22 : 64'h0),
                             (a == 2 || a == 7)});
        end
        for (int a = 7; a >= 0; a--) begin
            vecs.push_back('{1'b0, 3'(a), 64'h0, 64'(a * 32'h0101), 1'b1});
        end

        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        checkOutput("reset_req_ready", 64'(bus.req_ready), 64'd1);
        checkOutput("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("reset_stash_cnt", 64'(stash_cnt), 64'd0);
        checkOutput("reset_stash_ovf", 64'(stash_ovf), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            modelAccess(vecs[i].wr, vecs[i].addr, vecs[i].wdata, d_rd, d_hit);
            applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_hit, 0);
        end

        // Response held back for 10 cycles must stay stable
        modelOp(1'b0, 3'd3, 64'h0, 10);

        // Reset in the middle of write-back aborts the access and forgets everything
        modelOp(1'b1, 3'd4, 64'hCAFE_F00D_1234_5678, 0);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 3'd4;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("abort_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        checkOutput("abort_req_ready", 64'(bus.req_ready), 64'd1);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_stash_cnt", 64'(stash_cnt), 64'd0);
        seen_rsp = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.rsp_valid) seen_rsp++;
            @(posedge clk);
            #1;
        end
        checkOutput("abort_no_rsp", 64'(seen_rsp), 64'd0);
        modelOp(1'b0, 3'd4, 64'h0, 0);

        // Random traffic against the memory model
        for (int i = 0; i < 60; i++) begin
            modelOp(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), {$urandom, $urandom},
                    int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
